// File: rtl/hazard_ctrl_pkg.sv
// rtl/hazard_ctrl_pkg.sv - shared types for the pipeline hazard sequencer
package hazard_ctrl_pkg;

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    LOAD_USE = 2'd1,
    MEM_WAIT = 2'd2,
    REDIRECT = 2'd3
  } hz_state_e;

  typedef struct packed {
    logic en_f;
    logic en_d;
    logic en_e;
    logic en_w;
    logic flush_d;
    logic flush_e;
    logic flush_w;
  } hz_ctrl_t;

  localparam hz_ctrl_t CTRL_RUN   = '{en_f: 1'b1, en_d: 1'b1, en_e: 1'b1, en_w: 1'b1,
                                      flush_d: 1'b0, flush_e: 1'b0, flush_w: 1'b0};
  localparam hz_ctrl_t CTRL_RESET = '{en_f: 1'b0, en_d: 1'b0, en_e: 1'b0, en_w: 1'b0,
                                      flush_d: 1'b1, flush_e: 1'b1, flush_w: 1'b1};

  function automatic logic all_enabled(hz_ctrl_t c);
    return c.en_f & c.en_d & c.en_e & c.en_w;
  endfunction

endpackage

// File: rtl/hazard_ctrl_hz_timer.sv
// rtl/hazard_ctrl_hz_timer.sv - loadable up-counter with terminal-count flag
module hz_timer #(
  parameter int W  = 8,
  parameter int TC = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic         tc
);

  logic [W-1:0] count;

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (inc) begin
      count <= count + 1'b1;
    end
  end

  assign tc = (count == W'(TC));

endmodule

// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - stall/flush sequencer for the 4-stage pipeline
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 2,
  parameter int MEM_TIMEOUT  = 255,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       d_rs1,
  input  logic [4:0]       d_rs2,
  input  logic             d_use_rs1,
  input  logic             d_use_rs2,
  input  logic [4:0]       e_rd,
  input  logic             e_is_load,
  input  logic             mem_req,
  input  logic             mem_ack,
  input  logic             wb_jmp_tk,
  output logic             en_f,
  output logic             en_d,
  output logic             en_e,
  output logic             en_w,
  output logic             flush_d,
  output logic             flush_e,
  output logic             flush_w,
  output logic             mem_err,
  output logic [CNT_W-1:0] stall_cnt
);

  localparam int RD_W = $clog2(FLUSH_CYCLES + 1);
  localparam int MT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e state, state_nx;
  hz_ctrl_t  ctrl;
  logic      lu;
  logic      rd_load, rd_inc, rd_tc;
  logic      mt_load, mt_inc, mt_tc;

  assign lu = e_is_load && (e_rd != 5'd0) &&
              ((d_use_rs1 && (d_rs1 == e_rd)) || (d_use_rs2 && (d_rs2 == e_rd)));

  hz_timer #(.W(RD_W), .TC(FLUSH_CYCLES - 1)) u_redirect_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (rd_load),
    .load_val (RD_W'(1)),
    .inc      (rd_inc),
    .tc       (rd_tc)
  );

  hz_timer #(.W(MT_W), .TC(MEM_TIMEOUT)) u_mem_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (mt_load),
    .load_val (MT_W'(1)),
    .inc      (mt_inc),
    .tc       (mt_tc)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_nx;
    end
  end

  always_comb begin
    ctrl     = CTRL_RUN;
    state_nx = state;
    mem_err  = 1'b0;
    rd_load  = 1'b0;
    rd_inc   = 1'b0;
    mt_load  = 1'b0;
    mt_inc   = 1'b0;
    unique case (state)
      RUN, LOAD_USE: begin
        state_nx = RUN;
        if (wb_jmp_tk) begin
          ctrl.flush_d = 1'b1;
          ctrl.flush_e = 1'b1;
          ctrl.flush_w = 1'b1;
          rd_load      = 1'b1;
          if (FLUSH_CYCLES > 1) state_nx = REDIRECT;
        end else if (mem_req && !mem_ack) begin
          ctrl     = '0;
          mt_load  = 1'b1;
          state_nx = MEM_WAIT;
        end else if (lu && (state == RUN)) begin
          // The bubble lets the load reach writeback; LOAD_USE must not re-stall on it.
          ctrl.en_f    = 1'b0;
          ctrl.en_d    = 1'b0;
          ctrl.flush_e = 1'b1;
          state_nx     = LOAD_USE;
        end
      end
      REDIRECT: begin
        ctrl.flush_d = 1'b1;
        ctrl.flush_e = 1'b1;
        if (wb_jmp_tk) begin
          rd_load = 1'b1;
        end else if (rd_tc) begin
          state_nx = RUN;
        end else begin
          rd_inc = 1'b1;
        end
      end
      MEM_WAIT: begin
        // A redirect arriving here is dropped; writeback is frozen and re-presents it.
        if (mem_ack) begin
          state_nx = RUN;
        end else if (mt_tc) begin
          mem_err      = 1'b1;
          ctrl.flush_e = 1'b1;
          ctrl.flush_w = 1'b1;
          state_nx     = RUN;
        end else begin
          ctrl   = '0;
          mt_inc = 1'b1;
        end
      end
    endcase
    if (rst) begin
      ctrl    = CTRL_RESET;
      mem_err = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt <= '0;
    end else if (!all_enabled(ctrl)) begin
      stall_cnt <= stall_cnt + 1'b1;
    end
  end

  assign en_f    = ctrl.en_f;
  assign en_d    = ctrl.en_d;
  assign en_e    = ctrl.en_e;
  assign en_w    = ctrl.en_w;
  assign flush_d = ctrl.flush_d;
  assign flush_e = ctrl.flush_e;
  assign flush_w = ctrl.flush_w;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - scoreboard bench for hazard_ctrl against a cycle model
module tb_hazard_ctrl;

  localparam int FLUSH_CYCLES = 2;
  localparam int MEM_TIMEOUT  = 4;
  localparam int CNT_W        = 16;

  logic             clk;
  logic             rst;
  logic [4:0]       d_rs1, d_rs2, e_rd;
  logic             d_use_rs1, d_use_rs2, e_is_load;
  logic             mem_req, mem_ack, wb_jmp_tk;
  logic             en_f, en_d, en_e, en_w;
  logic             flush_d, flush_e, flush_w, mem_err;
  logic [CNT_W-1:0] stall_cnt;

  hazard_ctrl #(
    .FLUSH_CYCLES (FLUSH_CYCLES),
    .MEM_TIMEOUT  (MEM_TIMEOUT),
    .CNT_W        (CNT_W)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .d_rs1     (d_rs1),
    .d_rs2     (d_rs2),
    .d_use_rs1 (d_use_rs1),
    .d_use_rs2 (d_use_rs2),
    .e_rd      (e_rd),
    .e_is_load (e_is_load),
    .mem_req   (mem_req),
    .mem_ack   (mem_ack),
    .wb_jmp_tk (wb_jmp_tk),
    .en_f      (en_f),
    .en_d      (en_d),
    .en_e      (en_e),
    .en_w      (en_w),
    .flush_d   (flush_d),
    .flush_e   (flush_e),
    .flush_w   (flush_w),
    .mem_err   (mem_err),
    .stall_cnt (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    int               tag;
    logic [7:0]       ctl;
    logic [CNT_W-1:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;
  int   phase      = 0;

  // Reference model: remaining redirect cycles, wait cycles so far, bubble already taken.
  int               redir_left   = 0;
  int               waiting      = 0;
  bit               after_bubble = 1'b0;
  logic [CNT_W-1:0] stalls       = '0;

  task automatic model_push();
    exp_t       e;
    logic [3:0] en;
    logic [2:0] fl;
    logic       err;
    bit         hazard;
    bit         bubble_ok;
    e.tag = phase;
    e.cnt = stalls;
    if (rst) begin
      e.ctl        = 8'b0000_1110;
      redir_left   = 0;
      waiting      = 0;
      after_bubble = 1'b0;
      stalls       = '0;
      sb.push_back(e);
      return;
    end
    en = 4'b1111;
    fl = 3'b000;
    err = 1'b0;
    hazard = e_is_load && (e_rd != 0) &&
             ((d_use_rs1 && d_rs1 == e_rd) || (d_use_rs2 && d_rs2 == e_rd));
    if (waiting > 0) begin
      if (mem_ack) waiting = 0;
      else if (waiting == MEM_TIMEOUT) begin
        err = 1'b1;
        fl = 3'b011;
        waiting = 0;
      end else begin
        en = 4'b0000;
        waiting = waiting + 1;
      end
    end else if (redir_left > 0) begin
      fl = 3'b110;
      redir_left = wb_jmp_tk ? FLUSH_CYCLES - 1 : redir_left - 1;
    end else begin
      bubble_ok = !after_bubble;
      after_bubble = 1'b0;
      if (wb_jmp_tk) begin
        fl = 3'b111;
        redir_left = FLUSH_CYCLES - 1;
      end else if (mem_req && !mem_ack) begin
        en = 4'b0000;
        waiting = 1;
      end else if (hazard && bubble_ok) begin
        en = 4'b0011;
        fl = 3'b010;
        after_bubble = 1'b1;
      end
    end
    e.ctl = {en, fl, err};
    if (en != 4'b1111) stalls = stalls + 1'b1;
    sb.push_back(e);
  endtask

  task automatic tick();
    model_push();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_in();
    d_rs1 = 0; d_rs2 = 0; e_rd = 0;
    d_use_rs1 = 0; d_use_rs2 = 0; e_is_load = 0;
    mem_req = 0; mem_ack = 0; wb_jmp_tk = 0; rst = 0;
  endtask

  task automatic idle(int n);
    clear_in();
    repeat (n) tick();
  endtask

  exp_t mon_e;
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      compared++;
      if ({en_f, en_d, en_e, en_w, flush_d, flush_e, flush_w, mem_err} !== mon_e.ctl) begin
        mismatched++;
        $display("FAIL ctl phase %0d t=%0t: got en/flush/err=%b expected %b", mon_e.tag, $time,
                 {en_f, en_d, en_e, en_w, flush_d, flush_e, flush_w, mem_err}, mon_e.ctl);
      end
      compared++;
      if (stall_cnt !== mon_e.cnt) begin
        mismatched++;
        $display("FAIL stall_cnt phase %0d t=%0t: got %0d expected %0d", mon_e.tag, $time,
                 stall_cnt, mon_e.cnt);
      end
    end
  end

  initial begin
    clear_in();
    rst = 1;
    @(posedge clk); #1;
    @(posedge clk); #1;

    phase = 1;
    idle(3);
    rst = 1; tick(); tick();
    idle(2);

    phase = 2;
    clear_in(); e_is_load = 1; e_rd = 5; d_use_rs1 = 1; d_rs1 = 5;
    tick(); tick();
    idle(1);
    clear_in(); e_is_load = 1; e_rd = 0; d_use_rs1 = 1; d_rs1 = 0;
    tick();
    clear_in(); e_is_load = 1; e_rd = 7; d_use_rs2 = 1; d_rs2 = 7;
    tick();
    idle(1);

    phase = 3;
    clear_in(); mem_req = 1;
    repeat (3) tick();
    mem_ack = 1; tick();
    idle(1);
    mem_req = 1; mem_ack = 1; tick();
    idle(1);

    phase = 4;
    clear_in(); mem_req = 1;
    repeat (MEM_TIMEOUT + 1) tick();
    idle(2);

    phase = 5;
    clear_in(); wb_jmp_tk = 1; tick();
    idle(3);
    wb_jmp_tk = 1; tick(); tick(); tick();
    idle(3);

    phase = 6;
    clear_in(); wb_jmp_tk = 1; e_is_load = 1; e_rd = 3; d_use_rs1 = 1; d_rs1 = 3;
    tick();
    idle(2);
    mem_req = 1; tick();
    wb_jmp_tk = 1; tick(); tick();
    wb_jmp_tk = 0; mem_ack = 1; tick();
    clear_in(); wb_jmp_tk = 1; tick();
    idle(2);

    phase = 7;
    for (int i = 0; i < 3000; i++) begin
      d_rs1     = 5'($urandom_range(0, 3));
      d_rs2     = 5'($urandom_range(0, 3));
      e_rd      = 5'($urandom_range(0, 3));
      d_use_rs1 = 1'($urandom_range(0, 1));
      d_use_rs2 = 1'($urandom_range(0, 1));
      e_is_load = ($urandom_range(0, 99) < 50);
      mem_req   = ($urandom_range(0, 99) < 20);
      mem_ack   = ($urandom_range(0, 99) < 35);
      wb_jmp_tk = ($urandom_range(0, 99) < 8);
      rst       = ($urandom_range(0, 999) < 5);
      tick();
    end
    idle(2);

    @(negedge clk);
    #1;
    compared++;
    if (sb.size() != 0) begin
      mismatched++;
      $display("FAIL drain: got %0d pending expectations, expected 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
